// File: rtl/fire_pkg.sv
// Shared constants and types for the fire2 squeeze output-feature-map writer.
package fire_pkg;

    localparam int FIRE_WIDTH = 16;
    localparam int FIRE_CH    = 16;
    localparam int FIRE_WOUT  = 64;

    // Word address width of a WOUT x WOUT x CH feature map.
    function automatic int fire_addr_w(input int wout, input int ch);
        return $clog2(wout * wout * ch);
    endfunction

    localparam int FIRE_ADDR_W = fire_addr_w(FIRE_WOUT, FIRE_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fire_state_t;

endpackage

// File: rtl/fire2_squeeze_ofm_writer.sv
// Serialises one CH-word squeeze result per sample into a pixel-major RAM write
// stream, one word per cycle; flags the end of the layer and dropped samples.
module fire2_squeeze_ofm_writer
    import fire_pkg::*;
#(
    parameter int WOUT  = FIRE_WOUT,
    parameter int CH    = FIRE_CH,
    parameter int WIDTH = FIRE_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_i,
    input  logic [CH-1:0][WIDTH-1:0]          ofm_i,
    output logic                              wr_en_o,
    output logic [fire_addr_w(WOUT, CH)-1:0]  wr_addr_o,
    output logic [WIDTH-1:0]                  wr_data_o,
    output logic                              busy_o,
    output logic                              ram_feedback_o,
    output logic                              done_o,
    output logic                              overflow_o
);

    localparam int AW     = fire_addr_w(WOUT, CH);
    localparam int PIXELS = WOUT * WOUT;
    localparam int PW     = $clog2(PIXELS + 1);
    localparam int CW     = (CH > 1) ? $clog2(CH) : 1;

    fire_state_t       state;
    logic [CW-1:0]     ch_cnt;
    logic [PW-1:0]     pix_cnt;
    logic [WIDTH-1:0]  shadow [CH];

    logic              last_ch;
    logic              accept;
    logic [CW-1:0]     ch_inc;
    logic [PW-1:0]     pix_inc;
    logic [AW-1:0]     base_cur;
    logic [AW-1:0]     base_inc;

    always_comb begin
        last_ch  = (state == DRAIN) && (ch_cnt == CW'(CH - 1));
        accept   = sample_i && ((state == IDLE) || last_ch);
        ch_inc   = ch_cnt + 1'b1;
        pix_inc  = pix_cnt + 1'b1;
        base_cur = AW'(pix_cnt) * AW'(CH);
        base_inc = AW'(pix_inc) * AW'(CH);
    end

    // Channel 0 is forwarded straight from ofm_i on the capture edge, so the
    // shadow only has to supply channels 1..CH-1 afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < CH; i++) begin
                shadow[i] <= ofm_i[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ch_cnt         <= '0;
            pix_cnt        <= '0;
            wr_en_o        <= 1'b0;
            wr_addr_o      <= '0;
            wr_data_o      <= '0;
            busy_o         <= 1'b0;
            ram_feedback_o <= 1'b0;
            done_o         <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            ram_feedback_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_i) begin
                        state     <= DRAIN;
                        ch_cnt    <= '0;
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= base_cur;
                        wr_data_o <= ofm_i[0];
                        busy_o    <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_ch) begin
                        pix_cnt <= pix_inc;
                        if (pix_inc == PW'(PIXELS)) begin
                            state          <= DONE;
                            wr_en_o        <= 1'b0;
                            busy_o         <= 1'b0;
                            ram_feedback_o <= 1'b1;
                            done_o         <= 1'b1;
                        end else if (sample_i) begin
                            ch_cnt    <= '0;
                            wr_addr_o <= base_inc;
                            wr_data_o <= ofm_i[0];
                        end else begin
                            state   <= IDLE;
                            wr_en_o <= 1'b0;
                            busy_o  <= 1'b0;
                        end
                    end else begin
                        // Within a pixel the address steps by one word per channel.
                        ch_cnt    <= ch_inc;
                        wr_addr_o <= wr_addr_o + 1'b1;
                        wr_data_o <= shadow[ch_inc];
                        if (sample_i) begin
                            overflow_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fire2_squeeze_ofm_writer.sv
// Self-checking bench for fire2_squeeze_ofm_writer (WOUT=4, CH=16: 16 pixels,
// 256 words) against a cycle-stamped write-list model.
module tb_fire2_squeeze_ofm_writer;

    typedef struct packed {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  sample_i;
    logic [15:0][15:0]     ofm_i;
    logic                  wr_en_o;
    logic [7:0]            wr_addr_o;
    logic [15:0]           wr_data_o;
    logic                  busy_o;
    logic                  ram_feedback_o;
    logic                  done_o;
    logic                  overflow_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_err = 0;

    wr_t got_w[$];
    wr_t exp_w[$];
    int  got_fb[$];
    int  exp_fb[$];

    // Reference state: a sample is accepted once the previous burst has
    // reached its final write cycle, and only while pixels remain.
    int m_busy_until = 0;
    int m_pix        = 0;
    bit m_ovf        = 1'b0;

    fire2_squeeze_ofm_writer #(
        .WOUT  (4),
        .CH    (16),
        .WIDTH (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_i       (sample_i),
        .ofm_i          (ofm_i),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .busy_o         (busy_o),
        .ram_feedback_o (ram_feedback_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en_o === 1'b1) got_w.push_back('{cyc, int'(wr_addr_o), int'(wr_data_o)});
        if (ram_feedback_o === 1'b1) got_fb.push_back(cyc);
        if (busy_o !== wr_en_o) busy_err++;
    end

    task automatic model_cycle(input bit s, input bit r, input logic [15:0][15:0] d);
        int c;
        c = cyc;
        if (r) begin
            while (exp_w.size() > 0 && exp_w[exp_w.size()-1].cyc > c) void'(exp_w.pop_back());
            while (exp_fb.size() > 0 && exp_fb[exp_fb.size()-1] > c) void'(exp_fb.pop_back());
            m_pix        = 0;
            m_ovf        = 1'b0;
            m_busy_until = c + 1;
        end else if (s) begin
            if (c < m_busy_until) begin
                m_ovf = 1'b1;
            end else if (m_pix < 16) begin
                for (int k = 0; k < 16; k++)
                    exp_w.push_back('{c + 1 + k, m_pix * 16 + k, int'(d[k])});
                m_busy_until = c + 16;
                m_pix++;
                if (m_pix == 16) exp_fb.push_back(c + 17);
            end
        end
    endtask

    task automatic drive(input bit s, input bit r, input logic [15:0][15:0] d);
        sample_i = s;
        rst      = r;
        ofm_i    = d;
        model_cycle(s, r, d);
        @(posedge clk);
        #1;
        sample_i = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    function automatic logic [15:0][15:0] rand_data();
        logic [15:0][15:0] d;
        for (int k = 0; k < 16; k++) d[k] = 16'($urandom);
        return d;
    endfunction

    task automatic do_reset();
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b1, '0);
        got_w.delete();
        exp_w.delete();
        got_fb.delete();
        exp_fb.delete();
        busy_err = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_o); end
        if (wr_addr_o !== 8'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr_o); end
        if (wr_data_o !== 16'd0) begin failures++; $display("FAIL reset_wr_data got=%0d exp=0", wr_data_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        if (ram_feedback_o !== 1'b0) begin failures++; $display("FAIL reset_feedback got=%b exp=0", ram_feedback_o); end
        if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
        if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
    endtask

    task automatic test_single();
        logic [15:0][15:0] d;
        int c0;
        do_reset();
        for (int k = 0; k < 16; k++) d[k] = 16'(k + 1);
        c0 = cyc;
        drive(1'b1, 1'b0, d);
        idle(20);
        checks++;
        if (got_w.size() != 16) begin failures++; $display("FAIL single_count got=%0d exp=16", got_w.size()); end
        for (int i = 0; i < 16 && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== wr_t'{c0 + 1 + i, i, i + 1}) begin
                failures++;
                $display("FAIL single_write[%0d] got=cyc%0d/a%0d/d%0d exp=cyc%0d/a%0d/d%0d",
                         i, got_w[i].cyc - c0, got_w[i].addr, got_w[i].data, 1 + i, i, i + 1);
            end
        end
        checks += 2;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy_o); end
        if (busy_err != 0) begin failures++; $display("FAIL single_busy_vs_wr got=%0d exp=0", busy_err); end
    endtask

    task automatic test_back_to_back();
        int c0;
        do_reset();
        c0 = cyc;
        drive(1'b1, 1'b0, rand_data());
        idle(15);
        drive(1'b1, 1'b0, rand_data());
        idle(20);
        checks++;
        if (got_w.size() != exp_w.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_w.size(), exp_w.size()); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL b2b_write[%0d] got=cyc%0d/a%0d/d%0d exp=cyc%0d/a%0d/d%0d", i,
                         got_w[i].cyc, got_w[i].addr, got_w[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks++;
        if (got_w.size() < 17 || got_w[16].cyc != c0 + 17 || got_w[16].addr != 16) begin
            failures++;
            $display("FAIL b2b_second_start got_size=%0d exp=addr16 at cycle+17", got_w.size());
        end
        checks++;
        if (overflow_o !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", overflow_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(1'b1, 1'b0, rand_data());
        idle(5);
        drive(1'b1, 1'b0, rand_data());
        idle(20);
        checks += 2;
        if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
        if (got_w.size() != 16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", got_w.size()); end
        drive(1'b1, 1'b0, rand_data());
        idle(20);
        checks++;
        if (got_w.size() != exp_w.size()) begin failures++; $display("FAIL ovf_total got=%0d exp=%0d", got_w.size(), exp_w.size()); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL ovf_write[%0d] got=a%0d/d%0d exp=a%0d/d%0d", i,
                         got_w[i].addr, got_w[i].data, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks++;
        if (got_w.size() < 17 || got_w[16].addr != 16) begin
            failures++;
            $display("FAIL ovf_next_pixel got_size=%0d exp=addr16 next", got_w.size());
        end
    endtask

    task automatic test_full_layer();
        logic [15:0][15:0] d;
        do_reset();
        for (int p = 0; p < 16; p++) begin
            for (int k = 0; k < 16; k++) d[k] = 16'(p * 256 + k);
            drive(1'b1, 1'b0, d);
            idle(19);
        end
        idle(5);
        checks++;
        if (got_w.size() != 256) begin failures++; $display("FAIL full_count got=%0d exp=256", got_w.size()); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || (got_w[i].data / 256) * 16 + (got_w[i].data % 256) != got_w[i].addr) begin
                failures++;
                $display("FAIL full_write[%0d] got=a%0d/d%0d exp=a%0d/d%0d", i,
                         got_w[i].addr, got_w[i].data, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks += 4;
        if (got_fb.size() != 1) begin failures++; $display("FAIL full_fb_count got=%0d exp=1", got_fb.size()); end
        else if (got_w.size() > 0 && got_fb[0] != got_w[got_w.size()-1].cyc + 1)
            begin failures++; $display("FAIL full_fb_cycle got=%0d exp=%0d", got_fb[0], got_w[got_w.size()-1].cyc + 1); end
        if (exp_fb.size() != 1 || got_fb.size() != 1 || got_fb[0] != exp_fb[0])
            begin failures++; $display("FAIL full_fb_model got_n=%0d exp_n=%0d", got_fb.size(), exp_fb.size()); end
        if (done_o !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", done_o); end
        if (busy_err != 0) begin failures++; $display("FAIL full_busy_vs_wr got=%0d exp=0", busy_err); end
        drive(1'b1, 1'b0, rand_data());
        idle(3);
        drive(1'b1, 1'b0, rand_data());
        idle(5);
        checks += 4;
        if (got_w.size() != 256) begin failures++; $display("FAIL post_done_writes got=%0d exp=256", got_w.size()); end
        if (overflow_o !== 1'b0) begin failures++; $display("FAIL post_done_overflow got=%b exp=0", overflow_o); end
        if (got_fb.size() != 1) begin failures++; $display("FAIL post_done_fb got=%0d exp=1", got_fb.size()); end
        if (done_o !== 1'b1) begin failures++; $display("FAIL post_done_done got=%b exp=1", done_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 1'b0, rand_data());
            idle(19);
        end
        drive(1'b1, 1'b0, rand_data());
        idle(8);
        drive(1'b1, 1'b1, rand_data());
        checks += 7;
        if (wr_en_o !== 1'b0) begin failures++; $display("FAIL mid_rst_wr_en got=%b exp=0", wr_en_o); end
        if (wr_addr_o !== 8'd0) begin failures++; $display("FAIL mid_rst_addr got=%0d exp=0", wr_addr_o); end
        if (wr_data_o !== 16'd0) begin failures++; $display("FAIL mid_rst_data got=%0d exp=0", wr_data_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy_o); end
        if (ram_feedback_o !== 1'b0) begin failures++; $display("FAIL mid_rst_fb got=%b exp=0", ram_feedback_o); end
        if (done_o !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", done_o); end
        if (overflow_o !== 1'b0) begin failures++; $display("FAIL mid_rst_ovf got=%b exp=0", overflow_o); end
        idle(3);
        drive(1'b1, 1'b0, rand_data());
        idle(20);
        checks++;
        if (got_w.size() != 3 * 16 + 9 + 16) begin failures++; $display("FAIL mid_rst_count got=%0d exp=73", got_w.size()); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL mid_rst_write[%0d] got=cyc%0d/a%0d/d%0d exp=cyc%0d/a%0d/d%0d", i,
                         got_w[i].cyc, got_w[i].addr, got_w[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks++;
        if (got_w.size() < 58 || got_w[57].addr != 0) begin
            failures++;
            $display("FAIL mid_rst_restart got_size=%0d exp=addr0 after reset", got_w.size());
        end
    endtask

    task automatic test_random();
        bit s;
        bit r;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 399) == 0);
            if (cyc == m_busy_until) s = ($urandom_range(0, 1) == 0);
            else                     s = ($urandom_range(0, 11) == 0);
            drive(s, r, rand_data());
        end
        idle(20);
        checks++;
        if (got_w.size() != exp_w.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_w.size(), exp_w.size()); end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL rand_write[%0d] got=cyc%0d/a%0d/d%0d exp=cyc%0d/a%0d/d%0d", i,
                         got_w[i].cyc, got_w[i].addr, got_w[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
            end
        end
        checks += 4;
        if (got_fb != exp_fb) begin failures++; $display("FAIL rand_fb got_n=%0d exp_n=%0d", got_fb.size(), exp_fb.size()); end
        if (overflow_o !== m_ovf) begin failures++; $display("FAIL rand_overflow got=%b exp=%b", overflow_o, m_ovf); end
        if (done_o !== (m_pix == 16)) begin failures++; $display("FAIL rand_done got=%b exp=%b", done_o, m_pix == 16); end
        if (busy_err != 0) begin failures++; $display("FAIL rand_busy_vs_wr got=%0d exp=0", busy_err); end
    endtask

    initial begin
        rst      = 1'b1;
        sample_i = 1'b0;
        ofm_i    = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_layer();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fire2_squeeze_ofm_writer.md
FIRE2_SQUEEZE_OFM_WRITER -- requirements
Module: fire2_squeeze_ofm_writer

Interface
REQ-001 The block SHALL have parameter WOUT, default 64, meaning output feature-map width/height in pixels.
REQ-002 The block SHALL have parameter CH, default 16, meaning output channels per pixel sample.
REQ-003 The block SHALL have parameter WIDTH, default 16, meaning data word width.
REQ-004 The block SHALL have a single clock domain; reset is synchronous and active-high.
REQ-005 The port list SHALL be as follows:
- clk  in  1  clock.
- rst  in  1  sync active-high reset.
- sample_i  in  1  one-cycle pulse; ofm_i valid.
- ofm_i  in  CH x WIDTH  per-channel squeeze results.
- wr_en_o  out  1  RAM write strobe.
- wr_addr_o  out  clog2(WOUT*WOUT*CH)  RAM word address.
- wr_data_o  out  WIDTH  RAM write data.
- busy_o  out  1  serialization in progress.
- ram_feedback_o  out  1  one-cycle pulse: layer fully written.
- done_o  out  1  level: layer complete, held until rst.
- overflow_o  out  1  sticky: a sample was dropped.

Function
REQ-006 The FSM SHALL have three states, IDLE, DRAIN and DONE, with reset state IDLE.
REQ-007 In IDLE, a cycle with sample_i=1 SHALL copy all CH words of ofm_i into a shadow register, clear ch_cnt to 0 and enter DRAIN.
REQ-008 In DRAIN, each cycle SHALL drive wr_en_o=1, wr_data_o=shadow[ch_cnt] and wr_addr_o=pix_cnt*CH+ch_cnt, then increment ch_cnt.
REQ-009 Latency SHALL be fixed: the first write (ch 0) occurs the cycle after the sample_i capture edge, and the last (ch CH-1) occurs CH cycles after it.
REQ-010 On the cycle writing ch CH-1, pix_cnt SHALL increment; if the new pix_cnt equals WOUT*WOUT, the next state SHALL be DONE, otherwise IDLE.
REQ-011 sample_i=1 coinciding with the ch CH-1 write SHALL be accepted back-to-back: capture, ch_cnt=0, stay in DRAIN, with no idle cycle and no drop.
REQ-012 sample_i=1 in DRAIN with ch_cnt<CH-1 SHALL be dropped, SHALL set overflow_o, and SHALL leave shadow and the sequence unchanged.
REQ-013 On entering DONE, the block SHALL assert ram_feedback_o for exactly one cycle and set done_o=1.
REQ-014 In DONE, sample_i SHALL be ignored, with no write and no overflow; the extra trailing samples from the squeeze stage are legal.
REQ-015 busy_o SHALL equal 1 exactly when the state is DRAIN.
REQ-016 wr_en_o SHALL be 0 in IDLE and DONE, and wr_addr_o/wr_data_o are don't-care when wr_en_o=0.
REQ-017 Address arithmetic SHALL be unsigned, pixel-major (addr = pix*CH + ch), and reach at most WOUT*WOUT*CH-1 with no wrap.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 rst=1 SHALL force state=IDLE, ch_cnt=0, pix_cnt=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, ram_feedback_o=0, done_o=0 and overflow_o=0 on the next edge.
REQ-020 rst asserted mid-DRAIN SHALL abort the burst with no further writes, and a sample_i in the same cycle as rst SHALL be ignored.
REQ-021 Shadow register contents SHALL be don't-care after reset.

Structure
REQ-022 WIDTH, the fire2 channel count (16) and WOUT (64) SHALL be constants in shared package fire_pkg, together with a state enum typedef for IDLE/DRAIN/DONE.
REQ-023 The address width SHALL be derived via $clog2 in fire_pkg.
REQ-024 The block SHALL be a single module with no sub-module; the write RAM is external.

Verification (WOUT=4, CH=16: 16 pixels, 256 words)
REQ-025 Single sample with ofm_i[k]=k+1 -> 16 writes on consecutive cycles 1..16 after capture, addr 0..15, data 1..16, then busy_o=0.
REQ-026 16 samples spaced 20 cycles apart with data=pix*256+ch -> 256 writes, addr==data mapping exact, ram_feedback_o pulses once 1 cycle after the addr-255 write, and done_o=1.
REQ-027 Second sample exactly on the ch15 write cycle -> next write (addr 16) on the following cycle, overflow_o stays 0.
REQ-028 Second sample on the ch5 write cycle -> overflow_o=1, 16 writes total, pix_cnt=1.
REQ-029 After done_o, 2 more sample_i pulses -> no wr_en_o, overflow_o unchanged, and no second ram_feedback_o.
REQ-030 rst at ch 8 of pixel 3 -> wr_en_o=0 next cycle, all outputs at reset values, and the next sample writes addr 0..15.
